// File: rtl/divisor_restaurador_8bits.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, WIDTH iterations,
// then a one-cycle DONE state that presents quotient/remainder and pulses done.
module divisor_restaurador_8bits #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   p_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             carry;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtraction as complement plus carry-in; carry-out set means divisor <= shifted.
  always_comb begin
    shifted = (WIDTH+1)'({p_reg, q_reg[WIDTH-1]});
    trial   = {1'b0, shifted} + {1'b0, ~{1'b0, d_reg}} + (WIDTH+2)'(1);
    carry   = trial[WIDTH+1];
    p_next  = carry ? trial[WIDTH:0] : shifted;
    q_next  = {q_reg[WIDTH-2:0], carry};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_reg       <= '0;
      d_reg       <= '0;
      p_reg       <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              // Zero divisor short-circuits straight to DONE with saturated quotient.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              q_reg       <= dividend;
              d_reg       <= divisor;
              p_reg       <= '0;
              count       <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          p_reg <= p_next;
          q_reg <= q_next;
          if (count == LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= p_next[WIDTH-1:0];
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_restaurador_8bits.sv
// Directed and swept checks of the restoring divider: results, latency, busy span,
// divide-by-zero handling, ignored starts, async reset and back-to-back issue.
module tb_divisor_restaurador_8bits;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks;
  int errors;

  divisor_restaurador_8bits #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start after edge t; lat = edges from t until done is seen (bounded at 40).
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [7:0] q, output logic [7:0] r, output logic dz,
                        output int busy_cnt, output logic pulse_ok);
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    @(posedge clk); #1;
    lat   = 1;
    start = 1'b0;
    if (busy) busy_cnt++;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    @(posedge clk); #1;
    pulse_ok = !done && !busy;
  endtask

  task automatic check_div(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic edz,
                           input int elat);
    int lat, bc;
    logic [7:0] q, r;
    logic dz, pok;
    do_div(a, b, lat, q, r, dz, bc, pok);
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (q !== eq || r !== er || dz !== edz) begin
      errors++;
      $display("FAIL %s result got q=%0d r=%0d dz=%0b want q=%0d r=%0d dz=%0b",
               name, q, r, dz, eq, er, edz);
    end
    checks++;
    if (bc !== elat || pok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy/pulse got busy_cycles=%0d pulse_ok=%0b want %0d 1",
               name, bc, pok, elat);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset outputs got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    check_div("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
    check_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    check_div("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
    check_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
  endtask

  task automatic test_div_zero();
    check_div("77/0", 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
    check_div("10/3 after zero", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9);
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [7:0] q, r;
    ndone = 0;
    q = '0;
    r = '0;
    @(posedge clk); #1;
    dividend = 8'd100;
    divisor  = 8'd10;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        q = quotient;
        r = remainder;
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_start done count got %0d want 1", ndone);
    end
    checks++;
    if (q !== 8'd10 || r !== 8'd0) begin
      errors++;
      $display("FAIL ignore_start result got q=%0d r=%0d want q=10 r=0", q, r);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset outputs got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    check_div("50/6 after reset", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9);
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    logic [7:0] q, r;
    first  = -1;
    second = -1;
    n      = 0;
    q      = '0;
    r      = '0;
    @(posedge clk); #1;
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    for (int i = 1; i <= 30 && second < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = i;
        else second = i;
        q = quotient;
        r = remainder;
        n++;
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (n !== 2 || second - first !== 10) begin
      errors++;
      $display("FAIL back_to_back spacing got n=%0d spacing=%0d want 2 10", n, second - first);
    end
    checks++;
    if (q !== 8'd14 || r !== 8'd2) begin
      errors++;
      $display("FAIL back_to_back result got q=%0d r=%0d want q=14 r=2", q, r);
    end
  endtask

  task automatic test_random_sweep();
    int lat, bc, elat;
    logic [7:0] a, b, q, r, eq, er;
    logic dz, pok, edz;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; edz = 1'b1; elat = 1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; elat = 9;
      end
      do_div(a, b, lat, q, r, dz, bc, pok);
      checks++;
      if (lat !== elat || pok !== 1'b1) begin
        errors++;
        $display("FAIL sweep %0d/%0d timing got lat=%0d pulse_ok=%0b want %0d 1",
                 a, b, lat, pok, elat);
      end
      checks++;
      if (q !== eq || r !== er || dz !== edz) begin
        errors++;
        $display("FAIL sweep %0d/%0d result got q=%0d r=%0d dz=%0b want q=%0d r=%0d dz=%0b",
                 a, b, q, r, dz, eq, er, edz);
      end
      if (b != 8'd0) begin
        checks++;
        if ((int'(q) * int'(b) + int'(r)) !== int'(a) || r >= b) begin
          errors++;
          $display("FAIL sweep %0d/%0d identity got q=%0d r=%0d want q*d+r=a r<d",
                   a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
